// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: sequencing FSM for a single-MAC FIR datapath.
// Per sample: shift it into the delay line and clear the accumulator,
// then run one MAC per tap until the datapath tap counter carries, then
// hold the finished result until downstream takes it.
// An abort abandons the current computation. If the tap counter was left
// mid-count, it is stepped back to zero before the next sample is accepted.
// Optional build macro FIR_MAC_CTRL_STATS_EN adds the sample_count and
// abort_count statistics outputs.
module fir_mac_ctrl #(
    parameter int coefnum    = 64,
    parameter int logcoefnum = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        abort,
    input  logic        cnt_co,
    output logic        load,
    output logic        clr_res,
    output logic        loadres,
    output logic        cnt_en,
    output logic        busy
`ifdef FIR_MAC_CTRL_STATS_EN
    ,
    output logic [15:0] sample_count,
    output logic [7:0]  abort_count
`endif
);

    // The tap counter lives in the datapath; its width must cover every tap.
    generate
        if (logcoefnum != $clog2(coefnum)) begin : g_bad_width
            $error("fir_mac_ctrl: logcoefnum must equal clog2(coefnum)");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;
    // Set while IDLE is stepping a half-finished tap count back to zero.
    logic   drain_q, drain_d;

    // State and drain flag registers; reset abandons any work at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next-state and output decode. IDLE outputs are also gated by the
    // reset input so everything reads 0 while reset is held.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        clr_res   = 1'b0;
        loadres   = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain_q) begin
                    // Keep the accumulator cleared and run the counter
                    // until its carry cycle, after which it sits at zero.
                    busy    = 1'b1;
                    clr_res = 1'b1;
                    cnt_en  = 1'b1;
                    if (cnt_co) begin
                        drain_d = 1'b0;
                    end
                end else begin
                    in_ready = reset;
                    if (reset && in_valid) begin
                        load    = 1'b1;
                        clr_res = 1'b1;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                busy = 1'b1;
                if (abort) begin
                    // Counter is left at the current tap; drain it.
                    clr_res = 1'b1;
                    state_d = IDLE;
                    drain_d = 1'b1;
                end else begin
                    loadres = 1'b1;
                    cnt_en  = 1'b1;
                    if (cnt_co) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy = 1'b1;
                if (abort) begin
                    // Counter already wrapped to zero on the last tap,
                    // so only the result has to be discarded.
                    clr_res = 1'b1;
                    state_d = IDLE;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                drain_d = 1'b0;
            end
        endcase
    end

`ifdef FIR_MAC_CTRL_STATS_EN
    logic [15:0] sample_count_q;
    logic [7:0]  abort_count_q;
    logic        abort_take;

    assign abort_take   = abort && ((state_q == ACCUM) || (state_q == DONE));
    assign sample_count = sample_count_q;
    assign abort_count  = abort_count_q;

    // Completed-result counter wraps; abort counter sticks at its maximum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sample_count_q <= 16'd0;
            abort_count_q  <= 8'd0;
        end else begin
            if (out_valid && out_ready) begin
                sample_count_q <= sample_count_q + 16'd1;
            end
            if (abort_take && (abort_count_q != 8'hFF)) begin
                abort_count_q <= abort_count_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Testbench for fir_mac_ctrl with a 4-tap configuration and a small tap
// counter standing in for the datapath. Optional FIR_MAC_CTRL_STATS_EN
// also exercises the statistics outputs.
module tb_fir_mac_ctrl;

    localparam int COEFNUM = 4;
    localparam int LOGC    = 2;

    logic clock     = 1'b0;
    logic reset     = 1'b0;
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    logic abort     = 1'b0;
    logic in_ready, out_valid, load, clr_res, loadres, cnt_en, busy;
    logic cnt_co;
    logic [LOGC-1:0] cnt_q;
`ifdef FIR_MAC_CTRL_STATS_EN
    logic [15:0] sample_count;
    logic [7:0]  abort_count;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state: 0 idle, 1 accumulating, 2 result held, 3 draining
    int m_mode;
    int m_tap;
    int m_left;

    fir_mac_ctrl #(.coefnum(COEFNUM), .logcoefnum(LOGC)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .abort     (abort),
        .cnt_co    (cnt_co),
        .load      (load),
        .clr_res   (clr_res),
        .loadres   (loadres),
        .cnt_en    (cnt_en),
        .busy      (busy)
`ifdef FIR_MAC_CTRL_STATS_EN
        ,
        .sample_count (sample_count),
        .abort_count  (abort_count)
`endif
    );

    always #5 clock = ~clock;

    // Datapath tap counter: wraps at COEFNUM-1, carry while at the last tap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_co = (cnt_q == LOGC'(COEFNUM - 1));

    // {in_ready, out_valid, load, clr_res, loadres, cnt_en, busy}
    function automatic logic [6:0] outs();
        return {in_ready, out_valid, load, clr_res, loadres, cnt_en, busy};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            checks++;
            if (outs() !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: outputs=%b want 0000000", i, outs());
            end
        end
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy, load} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: in_ready,busy,load=%b want 100", {in_ready, busy, load});
        end
    endtask

    task automatic test_single();
        int n, acc;
        in_valid = 1'b1;
        #1;
        checks++;
        if ({in_ready, load, clr_res, loadres} !== 4'b1110) begin
            errors++;
            $display("FAIL single_accept: in_ready,load,clr_res,loadres=%b want 1110",
                     {in_ready, load, clr_res, loadres});
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        n = 0; acc = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            if (loadres && cnt_en && !clr_res) acc++;
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (n !== COEFNUM) begin
            errors++;
            $display("FAIL single_latency: edges=%0d want %0d", n, COEFNUM);
        end
        checks++;
        if (acc !== COEFNUM) begin
            errors++;
            $display("FAIL single_mac_cycles: got %0d want %0d", acc, COEFNUM);
        end
        checks++;
        if ({loadres, cnt_en, load, in_ready, busy} !== 5'b00001) begin
            errors++;
            $display("FAIL single_done_outputs: got %b want 00001",
                     {loadres, cnt_en, load, in_ready, busy});
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock); #1;
            checks++;
            if ({out_valid, loadres, in_ready, cnt_en, busy} !== 5'b10001) begin
                errors++;
                $display("FAIL backpressure cycle %0d: ov,loadres,in_ready,cnt_en,busy=%b want 10001",
                         i, {out_valid, loadres, in_ready, cnt_en, busy});
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errors++;
            $display("FAIL backpressure_release: in_ready,busy,ov=%b want 100",
                     {in_ready, busy, out_valid});
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int accepts, ovs, last_acc, bad_gap;
        accepts = 0; ovs = 0; last_acc = -1; bad_gap = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5 * (COEFNUM + 2); c++) begin
            @(negedge clock); #1;
            if (load) begin
                if (last_acc >= 0 && (c - last_acc) != COEFNUM + 2) bad_gap++;
                last_acc = c;
                accepts++;
            end
            if (out_valid) ovs++;
        end
        in_valid = 1'b0;
        checks++;
        if (accepts !== 5 || bad_gap !== 0) begin
            errors++;
            $display("FAIL b2b_accepts: accepts=%0d bad_gaps=%0d want 5 and 0", accepts, bad_gap);
        end
        checks++;
        if (ovs !== 5) begin
            errors++;
            $display("FAIL b2b_results: out_valid cycles=%0d want 5", ovs);
        end
        checks++;
        if (last_acc !== 4 * (COEFNUM + 2)) begin
            errors++;
            $display("FAIL b2b_last_accept: cycle=%0d want %0d", last_acc, 4 * (COEFNUM + 2));
        end
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int n, drain;
        logic ov;
        @(negedge clock); in_valid = 1'b1;
        @(negedge clock); in_valid = 1'b0;
        @(negedge clock); abort = 1'b1;
        #1;
        checks++;
        if ({loadres, cnt_en, out_valid, clr_res, busy} !== 5'b00011 || cnt_q !== 2'd1) begin
            errors++;
            $display("FAIL abort_cycle: loadres,cnt_en,ov,clr_res,busy=%b tap=%0d want 00011 tap=1",
                     {loadres, cnt_en, out_valid, clr_res, busy}, cnt_q);
        end
        @(negedge clock); abort = 1'b0;
        #1;
        n = 0; drain = 0; ov = 1'b0;
        while (in_ready !== 1'b1 && n < 20) begin
            if (cnt_en && busy && !in_ready && !loadres) drain++;
            if (out_valid) ov = 1'b1;
            @(negedge clock); #1;
            n++;
        end
        checks++;
        if (drain !== COEFNUM - 1) begin
            errors++;
            $display("FAIL abort_drain_cycles: got %0d want %0d", drain, COEFNUM - 1);
        end
        checks++;
        if (ov !== 1'b0 || cnt_q !== 2'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_end: ov_seen=%b tap=%0d in_ready=%b want 0 0 1", ov, cnt_q, in_ready);
        end
    endtask

    task automatic test_abort_done();
        int n;
        logic ov;
        @(negedge clock); in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clock); in_valid = 1'b0;
        #1;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clock); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_done_reach: out_valid=%b want 1", out_valid);
        end
        abort = 1'b1;
        #1;
        checks++;
        if ({out_valid, loadres, cnt_en} !== 3'b000) begin
            errors++;
            $display("FAIL abort_done_cycle: ov,loadres,cnt_en=%b want 000", {out_valid, loadres, cnt_en});
        end
        @(negedge clock); abort = 1'b0;
        #1;
        n = 0; ov = 1'b0;
        while (busy !== 1'b0 && n < 20) begin
            if (out_valid) ov = 1'b1;
            @(negedge clock); #1;
            n++;
        end
        checks++;
        if ({ov, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_done_end: ov_seen,busy=%b want 00", {ov, busy});
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock); in_valid = 1'b1;
        @(negedge clock); in_valid = 1'b0;
        @(posedge clock); #3;
        in_valid = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== 7'b0 || cnt_q !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: outputs=%b tap=%0d want 0000000 tap=0", outs(), cnt_q);
        end
        @(negedge clock); in_valid = 1'b0;
        @(negedge clock); reset = 1'b1;
        #1;
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL async_reset_release: in_ready,busy=%b want 10", {in_ready, busy});
        end
    endtask

    task automatic test_random();
        logic [6:0] exp;
        logic iv, orr, ab;
        m_mode = 0; m_tap = 0; m_left = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            iv  = 1'($urandom_range(0, 1));
            orr = 1'($urandom_range(0, 1));
            ab  = ($urandom_range(0, 11) == 0);
            in_valid = iv; out_ready = orr; abort = ab;
            #1;
            exp = 7'b0;
            case (m_mode)
                0: begin
                    exp[6] = 1'b1;
                    exp[4] = iv;
                    exp[3] = iv;
                    if (iv) begin m_mode = 1; m_tap = 0; end
                end
                1: begin
                    exp[0] = 1'b1;
                    if (ab) begin
                        exp[3] = 1'b1;
                        m_left = COEFNUM - m_tap;
                        m_mode = 3;
                    end else begin
                        exp[2] = 1'b1;
                        exp[1] = 1'b1;
                        m_tap++;
                        if (m_tap == COEFNUM) m_mode = 2;
                    end
                end
                2: begin
                    exp[0] = 1'b1;
                    if (ab) begin
                        exp[3] = 1'b1;
                        m_mode = 0;
                    end else begin
                        exp[5] = 1'b1;
                        if (orr) m_mode = 0;
                    end
                end
                default: begin
                    exp[0] = 1'b1;
                    exp[3] = 1'b1;
                    exp[1] = 1'b1;
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            endcase
            checks++;
            if (outs() !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: outputs=%b want %b (in_valid=%b out_ready=%b abort=%b)",
                         c, outs(), exp, iv, orr, ab);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    endtask

`ifdef FIR_MAC_CTRL_STATS_EN
    task automatic test_stats();
        @(negedge clock); reset = 1'b0;
        @(negedge clock); @(negedge clock); reset = 1'b1;
        #1;
        checks++;
        if (sample_count !== 16'd0 || abort_count !== 8'd0) begin
            errors++;
            $display("FAIL stats_reset: sample_count=%0d abort_count=%0d want 0 0", sample_count, abort_count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); in_valid = 1'b1;
            @(negedge clock); in_valid = 1'b0;
            repeat (COEFNUM + 2) @(negedge clock);
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (sample_count !== 16'd3) begin
            errors++;
            $display("FAIL stats_samples: sample_count=%0d want 3", sample_count);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clock); in_valid = 1'b1;
            @(negedge clock); in_valid = 1'b0; abort = 1'b1;
            @(negedge clock); abort = 1'b0;
            repeat (COEFNUM + 1) @(negedge clock);
            if (i == 9) begin
                #1;
                checks++;
                if (abort_count !== 8'd10) begin
                    errors++;
                    $display("FAIL stats_aborts_10: abort_count=%0d want 10", abort_count);
                end
            end
        end
        #1;
        checks++;
        if (abort_count !== 8'd255 || sample_count !== 16'd3) begin
            errors++;
            $display("FAIL stats_aborts_sat: abort_count=%0d sample_count=%0d want 255 3",
                     abort_count, sample_count);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_abort_done();
        test_async_reset();
        test_random();
`ifdef FIR_MAC_CTRL_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
